sram_controller: RTL and testbench

//  Services 32-bit load/store requests from the MEM stage on a 16-bit external SRAM
//  (256K x 16, DE2-class). Each word access takes two 16-bit half-word phases plus wait states.
//  The controller holds ready low while an access is in flight. The pipeline uses ~ready as

---
 rtl/sram_controller_pkg.sv | 26 ++
 rtl/sram_controller.sv | 129 ++++++++++++
 tb/tb_sram_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_controller_pkg                                              |
// | Brief   : Shared types, defaults and address helper for sram_controller.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
package sram_controller_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [31:0] c_BASE_ADDR_DEFAULT     = 32'd1024;
   localparam int          c_SRAM_ADDR_W_DEFAULT   = 18;
   localparam int          c_ACCESS_CYCLES_DEFAULT = 5;

   // Byte address relative to the SRAM window, as a 32-bit word index.
   function automatic logic [31:0] byte_to_word(input logic [31:0] addr,
                                                input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_controller                                                  |
// | Brief   : 32-bit load/store port onto a 16-bit async SRAM, two half-word   |
// |           phases plus wait states; ready low freezes the pipeline.         |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = c_BASE_ADDR_DEFAULT,
   parameter int          SRAM_ADDR_W   = c_SRAM_ADDR_W_DEFAULT,
   parameter int          ACCESS_CYCLES = c_ACCESS_CYCLES_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [15:0]            sram_dq,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic                   sram_we_n,
   output logic                   sram_ub_n,
   output logic                   sram_lb_n,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n
);

   localparam int                 c_CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam int                 c_WADDR_W  = SRAM_ADDR_W - 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ACCESS_CYCLES - 1);

   state_t                 r_state, w_state_next;
   logic [c_CNT_W-1:0]     r_cnt, w_cnt_next;
   logic                   r_write;
   logic [c_WADDR_W-1:0]   r_waddr;
   logic [31:0]            r_wdata;
   logic                   r_dq_oe;
   logic [15:0]            r_dq_out;
   logic [31:0]            w_word;
   logic                   w_req, w_accept, w_lo_phase, w_hi_phase;
   logic                   w_unused;

   assign w_req      = rd_en | wr_en;
   assign w_word     = byte_to_word(address, BASE_ADDR);
   assign w_accept   = (r_state == S_IDLE) && w_req;
   assign w_lo_phase = (r_state == S_ACCESS) && (r_cnt == c_CNT_W'(0));
   assign w_hi_phase = (r_state == S_ACCESS) && (r_cnt == c_CNT_W'(1));
   // Upper word-index bits fall outside the SRAM, so accesses wrap.
   assign w_unused   = &{1'b0, w_word[31:c_WADDR_W]};

   assign sram_dq   = r_dq_oe ? r_dq_out : 16'bz;
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;
   assign sram_ce_n = 1'b0;
   assign sram_oe_n = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      ready        = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            // Freeze must assert in the request cycle itself.
            ready = ~w_req;
            if (w_req) begin
               w_state_next = S_ACCESS;
               w_cnt_next   = '0;
            end
         end
         S_ACCESS: begin
            ready = 1'b0;
            if (r_cnt == c_CNT_LAST) w_state_next = S_DONE;
            else                     w_cnt_next   = r_cnt + 1'b1;
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // SRAM strobes are registered one edge ahead of the phase they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data <= '0;
         sram_we_n <= 1'b1;
         sram_addr <= '0;
         r_dq_oe   <= 1'b0;
         r_dq_out  <= '0;
         r_write   <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
      end else begin
         sram_we_n <= 1'b1;
         r_dq_oe   <= 1'b0;
         if (w_accept) begin
            r_write   <= wr_en;
            r_waddr   <= w_word[c_WADDR_W-1:0];
            r_wdata   <= write_data;
            sram_addr <= {w_word[c_WADDR_W-1:0], 1'b0};
            sram_we_n <= ~wr_en;
            r_dq_oe   <= wr_en;
            r_dq_out  <= write_data[15:0];
         end else if (w_lo_phase) begin
            sram_addr <= {r_waddr, 1'b1};
            sram_we_n <= ~r_write;
            r_dq_oe   <= r_write;
            r_dq_out  <= r_wdata[31:16];
            if (!r_write) read_data[15:0] <= sram_dq;
         end else if (w_hi_phase) begin
            if (!r_write) read_data[31:16] <= sram_dq;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sram_controller                                               |
// | Brief   : Directed bench with transaction-level model and SRAM arrays.     |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sram_controller;

   localparam int AC = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

   logic        rd3, wr3;
   logic [31:0] addr3, wd3, rdata3;
   logic        ready3;
   wire  [15:0] dq3;
   logic [17:0] saddr3;
   logic        we3_n, ub3_n, lb3_n, ce3_n, oe3_n;

   logic [15:0] mem  [0:262143];
   logic [15:0] mem3 [0:262143];

   assign sram_dq = (sram_we_n && !sram_oe_n) ? mem[sram_addr] : 16'hzzzz;
   assign dq3     = (we3_n && !oe3_n) ? mem3[saddr3] : 16'hzzzz;
   always @(posedge clk) if (!sram_we_n) mem[sram_addr] <= sram_dq;
   always @(posedge clk) if (!we3_n) mem3[saddr3] <= dq3;

   sram_controller dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
      .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n)
   );

   sram_controller #(.ACCESS_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .rd_en(rd3), .wr_en(wr3), .address(addr3),
      .write_data(wd3), .read_data(rdata3), .ready(ready3),
      .sram_dq(dq3), .sram_addr(saddr3), .sram_we_n(we3_n),
      .sram_ub_n(ub3_n), .sram_lb_n(lb3_n), .sram_ce_n(ce3_n),
      .sram_oe_n(oe3_n)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: request cycle, AC access cycles, one done cycle.
   logic [31:0] shadow [int];
   int          phase = 0;
   logic        m_write;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] exp_rd = 32'd0;

   function automatic int widx(input logic [31:0] a);
      return int'(((a - 32'd1024) >> 2) % 32'd131072);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         phase  = 0;
         exp_rd = 32'd0;
      end else if (phase == 0) begin
         check("idle_ready", ready, !(rd_en | wr_en));
         check("idle_we_n", sram_we_n, 1);
         check("idle_read_data", read_data, exp_rd);
         if (rd_en | wr_en) begin
            m_write = wr_en;
            m_addr  = address;
            m_wdata = write_data;
            phase   = 1;
         end
      end else if (phase <= AC) begin
         check("access_ready", ready, 0);
         check("access_we_n", sram_we_n, (m_write && phase <= 2) ? 1'b0 : 1'b1);
         phase++;
      end else begin
         check("done_ready", ready, 1);
         if (m_write) shadow[widx(m_addr)] = m_wdata;
         else exp_rd = shadow.exists(widx(m_addr)) ? shadow[widx(m_addr)] : 32'd0;
         check("done_read_data", read_data, exp_rd);
         phase = 0;
      end
   end

   task automatic run(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input bit hold,
                      output int low, output int welow, output logic [31:0] rdata);
      bit done;
      rd_en = rd; wr_en = wr; address = a; write_data = d;
      low = 0; welow = 0; done = 0; rdata = '0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ready) begin
            rdata = read_data;
            done  = 1;
            break;
         end
         low++;
         if (!sram_we_n) welow++;
      end
      check("access_completes", done, 1);
      @(posedge clk); #1;
      if (!hold) begin rd_en = 0; wr_en = 0; end
   endtask

   int          low, welow, low3;
   logic [31:0] rdv;
   bit          done3;

   initial begin
      rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
      rd3 = 0; wr3 = 0; addr3 = 0; wd3 = 0;
      for (int i = 0; i < 262144; i++) begin mem[i] = 16'h0; mem3[i] = 16'h0; end
      repeat (2) @(posedge clk); #1;
      check("rst_ready", ready, 1);
      check("rst_read_data", read_data, 0);
      check("rst_we_n", sram_we_n, 1);
      check("rst_sram_addr", sram_addr, 0);
      check("tied_strobes", {sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n}, 0);
      rst = 0;

      // 1: store
      run(0, 1, 32'd1024, 32'hDEADBEEF, 0, low, welow, rdv);
      check("t1_low_cycles", low, 6);
      check("t1_we_low_cycles", welow, 2);
      check("t1_mem0", mem[0], 16'hBEEF);
      check("t1_mem1", mem[1], 16'hDEAD);

      // 2: load
      run(1, 0, 32'd1024, 32'h0, 0, low, welow, rdv);
      check("t2_read_data", rdv, 32'hDEADBEEF);
      check("t2_low_cycles", low, 6);

      // 3: store, idle, load
      run(0, 1, 32'd1028, 32'hCAFEF00D, 0, low, welow, rdv);
      repeat (3) @(posedge clk); #1;
      check("t3_read_data_held", read_data, 32'hDEADBEEF);
      check("t3_mem2", mem[2], 16'hF00D);
      check("t3_mem3", mem[3], 16'hCAFE);
      run(1, 0, 32'd1024, 32'h0, 0, low, welow, rdv);
      check("t3_load_1024", rdv, 32'hDEADBEEF);
      run(1, 0, 32'd1028, 32'h0, 0, low, welow, rdv);
      check("t3_load_1028", rdv, 32'hCAFEF00D);

      // 4: rd_en and wr_en together -> write
      run(1, 1, 32'd1032, 32'h12345678, 0, low, welow, rdv);
      check("t4_we_low_cycles", welow, 2);
      check("t4_mem4", mem[4], 16'h5678);
      check("t4_mem5", mem[5], 16'h1234);
      check("t4_read_data_kept", read_data, 32'hCAFEF00D);

      // Boundaries: wrap past the top of SRAM, ignored low address bits
      run(1, 0, 32'd1024 + 32'd524288, 32'h0, 0, low, welow, rdv);
      check("wrap_load", rdv, 32'hDEADBEEF);
      run(1, 0, 32'd1026, 32'h0, 0, low, welow, rdv);
      check("unaligned_load", rdv, 32'hDEADBEEF);

      // 6: back-to-back loads with rd_en held through DONE
      run(1, 0, 32'd1028, 32'h0, 1, low, welow, rdv);
      check("t6_first_load", rdv, 32'hCAFEF00D);
      run(1, 0, 32'd1028, 32'h0, 0, low, welow, rdv);
      check("t6_second_load", rdv, 32'hCAFEF00D);
      check("t6_second_low", low, 6);

      // 5: reset during the high-half phase of a store
      wr_en = 1; address = 32'd1040; write_data = 32'hA5A55A5A;
      @(posedge clk); @(posedge clk); #1;
      rst = 1; wr_en = 0;
      #1;
      check("t5_ready_async", ready, 1);
      check("t5_we_n_async", sram_we_n, 1);
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      check("t5_mem8_low_written", mem[8], 16'h5A5A);
      check("t5_mem9_untouched", mem[9], 16'h0000);
      check("t5_read_data_cleared", read_data, 32'h0);
      repeat (2) @(posedge clk); #1;

      // ACCESS_CYCLES=3 instance: 4 low / 1 high
      wr3 = 1; addr3 = 32'd1024; wd3 = 32'h0BADF00D;
      low3 = 0; done3 = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ready3) begin done3 = 1; break; end
         low3++;
      end
      check("ac3_store_done", done3, 1);
      check("ac3_store_low", low3, 4);
      @(posedge clk); #1;
      wr3 = 0;
      check("ac3_mem0", mem3[0], 16'hF00D);
      check("ac3_mem1", mem3[1], 16'h0BAD);
      rd3 = 1;
      low3 = 0; done3 = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ready3) begin done3 = 1; break; end
         low3++;
      end
      check("ac3_load_done", done3, 1);
      check("ac3_load_low", low3, 4);
      check("ac3_read_data", rdata3, 32'h0BADF00D);
      @(posedge clk); #1;
      rd3 = 0;
      #1;
      check("ac3_idle_ready", ready3, 1);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
